// File: rtl/sol32_data_responder.sv
// sol32_data_responder
//   Data-side memory responder for sol32core. A single-port word RAM sits
//   behind a posted write buffer:
//   - Stores retire in one cycle into the buffer.
//   - Loads return combinationally, with per-byte forwarding from pending
//     stores.
//   - Buffered stores drain to RAM only on idle bus cycles.
//
// Optional feature (macro SOL32_DATA_ALIGN_CHECK_EN):
//   Adds a registered Fault output. Misaligned accesses pulse Fault for one
//   cycle. A misaligned store is dropped; a misaligned load returns zero.
//   With the macro undefined, misaligned addresses are force-aligned.
//
// Ports:
//   Clock          core clock, all state changes on posedge
//   Reset          synchronous, active-high
//   ReadEnable     load request this cycle
//   WriteEnable    store request this cycle (never with ReadEnable)
//   DataWidth      00 byte, 01 half, 10/11 word
//   MemoryAddress  byte address
//   DataOut        store data from the core, right-aligned
//   DataIn         load data to the core, right-aligned, zero-extended
//   Stall          store refused this cycle because the buffer is full
//   WbCount        current buffer occupancy
//   Fault          (macro only) misaligned-access pulse
module sol32_data_responder #(
  parameter int WORD_ADDR_BITS = 10,
  parameter int WB_DEPTH       = 4
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      ReadEnable,
  input  logic                      WriteEnable,
  input  logic [1:0]                DataWidth,
  input  logic [31:0]               MemoryAddress,
  input  logic [31:0]               DataOut,
  output logic [31:0]               DataIn,
  output logic                      Stall,
  output logic [$clog2(WB_DEPTH):0] WbCount
`ifdef SOL32_DATA_ALIGN_CHECK_EN
  ,
  output logic                      Fault
`endif
);

  localparam int PTR_W     = $clog2(WB_DEPTH);
  localparam int CNT_W     = PTR_W + 1;
  localparam int RAM_DEPTH = 1 << WORD_ADDR_BITS;

  // Lane extraction: shift the merged word down to the addressed lane and
  // zero-extend to the access size.
  function automatic logic [31:0] extract_lane(input logic [31:0] word,
                                               input logic [1:0]  lane,
                                               input logic [1:0]  width);
    logic [31:0] shifted;
    shifted = word >> {lane, 3'b000};
    case (width)
      2'b00:   extract_lane = {24'b0, shifted[7:0]};
      2'b01:   extract_lane = {16'b0, shifted[15:0]};
      default: extract_lane = shifted;
    endcase
  endfunction

  logic [31:0]               mem [RAM_DEPTH];

  logic [WORD_ADDR_BITS-1:0] wb_word [WB_DEPTH];
  logic [3:0]                wb_be   [WB_DEPTH];
  logic [31:0]               wb_data [WB_DEPTH];

  logic [PTR_W-1:0]          head;
  logic [PTR_W-1:0]          tail;
  logic [CNT_W-1:0]          count;

  logic [WORD_ADDR_BITS-1:0] word_idx;
  logic [1:0]                lane;
  logic [3:0]                st_be;
  logic [31:0]               st_data;
  logic                      full;
  logic                      access_ok;
  logic                      enq;
  logic                      deq;
  logic [31:0]               merged;
  logic [PTR_W-1:0]          rd_idx;
  logic                      unused_addr;

  assign word_idx    = MemoryAddress[WORD_ADDR_BITS+1:2];
  assign unused_addr = ^MemoryAddress[31:WORD_ADDR_BITS+2];

  // Natural alignment: halves keep bit 1, words drop both low bits.
  always_comb begin
    lane    = 2'b00;
    st_be   = 4'b1111;
    st_data = DataOut;
    case (DataWidth)
      2'b00: begin
        lane    = MemoryAddress[1:0];
        st_be   = 4'b0001 << MemoryAddress[1:0];
        st_data = {4{DataOut[7:0]}};
      end
      2'b01: begin
        lane    = {MemoryAddress[1], 1'b0};
        st_be   = MemoryAddress[1] ? 4'b1100 : 4'b0011;
        st_data = {2{DataOut[15:0]}};
      end
      default: begin
        lane    = 2'b00;
        st_be   = 4'b1111;
        st_data = DataOut;
      end
    endcase
  end

`ifdef SOL32_DATA_ALIGN_CHECK_EN
  logic misaligned;
  logic fault_p1;

  always_comb begin
    case (DataWidth)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = MemoryAddress[0];
      default: misaligned = |MemoryAddress[1:0];
    endcase
  end

  assign access_ok = !misaligned;

  // A stalled store is not yet a request; it faults only once accepted.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      fault_p1 <= 1'b0;
    end else begin
      fault_p1 <= misaligned && (ReadEnable || (WriteEnable && !full));
    end
  end

  assign Fault = fault_p1;
`else
  assign access_ok = 1'b1;
`endif

  assign full    = (count == CNT_W'(WB_DEPTH));
  assign Stall   = WriteEnable && full;
  assign enq     = WriteEnable && !full && access_ok;
  // The array is single-ported: only a cycle with no core access may drain.
  assign deq     = !ReadEnable && !WriteEnable && (count != '0);
  assign WbCount = count;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) begin
        tail  <= tail + 1'b1;
        count <= count + 1'b1;
      end else if (deq) begin
        head  <= head + 1'b1;
        count <= count - 1'b1;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (enq) begin
      wb_word[tail] <= word_idx;
      wb_be[tail]   <= st_be;
      wb_data[tail] <= st_data;
    end
  end

  // Drain is suppressed under reset so a discarded entry never lands in RAM.
  always_ff @(posedge Clock) begin
    if (deq && !Reset) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_be[head][b]) begin
          mem[wb_word[head]][8*b +: 8] <= wb_data[head][8*b +: 8];
        end
      end
    end
  end

  // Walk valid entries oldest to newest so the newest store wins per byte.
  always_comb begin
    merged = mem[word_idx];
    rd_idx = head;
    for (int i = 0; i < WB_DEPTH; i++) begin
      rd_idx = head + PTR_W'(i);
      if ((CNT_W'(i) < count) && (wb_word[rd_idx] == word_idx)) begin
        for (int b = 0; b < 4; b++) begin
          if (wb_be[rd_idx][b]) begin
            merged[8*b +: 8] = wb_data[rd_idx][8*b +: 8];
          end
        end
      end
    end
  end

  assign DataIn = (ReadEnable && access_ok) ? extract_lane(merged, lane, DataWidth)
                                            : 32'b0;

endmodule
